// File: rtl/lsu_mem_ctrl.sv
// Load/store unit memory controller: one core load/store -> one req/gnt/rvalid bus transaction.
// Optional LSU_MISALIGN_TRAP_EN: misaligned accesses skip the bus and report o_misalign in DONE.
module lsu_mem_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_stall,
  output logic        o_bus_err,
  output logic        o_misalign,
  output logic        o_req,
  output logic        o_we,
  output logic [31:0] o_maddr,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  input  logic        i_gnt,
  input  logic        i_rvalid,
  input  logic [31:0] i_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  boff_q, boff_d;
  logic        req_q, req_d, we_q, we_d, berr_q, berr_d;
  logic [31:0] maddr_q, maddr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [3:0]  st_strb;
  logic [31:0] st_data, fmt_rdata;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic        tmo_hit, is_wr;

  assign is_wr   = i_mem_write;
  assign tmo_hit = (cnt_q == 8'(TIMEOUT_CYCLES - 1));

  // funct3[1:0]: 00 byte, 01 half, 1x word (covers the undefined encodings)
  always_comb begin
    st_strb = 4'b1111;
    st_data = i_wdata;
    case (i_funct3[1:0])
      2'b00: begin
        st_strb = 4'b0001 << i_addr[1:0];
        st_data = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        st_strb = i_addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{i_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_b = i_rdata[7:0];
    case (boff_q)
      2'd1:    ld_b = i_rdata[15:8];
      2'd2:    ld_b = i_rdata[23:16];
      2'd3:    ld_b = i_rdata[31:24];
      default: ;
    endcase
    ld_h = boff_q[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (f3_q[1:0])
      2'b00:   fmt_rdata = f3_q[2] ? {24'b0, ld_b} : {{24{ld_b[7]}}, ld_b};
      2'b01:   fmt_rdata = f3_q[2] ? {16'b0, ld_h} : {{16{ld_h[15]}}, ld_h};
      default: fmt_rdata = i_rdata;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic mis_q, mis_d, misal;
  assign misal = (i_funct3[1:0] == 2'b01 && i_addr[0]) ||
                 (i_funct3[1]          && i_addr[1:0] != 2'b00);
  assign o_misalign = mis_q;
`else
  assign o_misalign = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    f3_d    = f3_q;
    boff_d  = boff_q;
    req_d   = req_q;
    we_d    = we_q;
    berr_d  = berr_q;
    maddr_d = maddr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    o_stall = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    mis_d   = mis_q;
`endif
    case (state_q)
      S_IDLE: begin
        o_stall = i_mem_read | i_mem_write;
        if (i_mem_read | i_mem_write) begin
          f3_d    = i_funct3;
          boff_d  = i_addr[1:0];
          we_d    = is_wr;
          maddr_d = {i_addr[31:2], 2'b00};
          wdata_d = st_data;
          wstrb_d = is_wr ? st_strb : 4'b0000;
          state_d = S_REQ;
          req_d   = 1'b1;
          cnt_d   = 8'd0;
`ifdef LSU_MISALIGN_TRAP_EN
          if (misal) begin
            state_d = S_DONE;
            req_d   = 1'b0;
            mis_d   = 1'b1;
          end
`endif
        end
      end
      S_REQ: begin
        o_stall = 1'b1;
        cnt_d   = cnt_q + 8'd1;
        if (i_gnt) begin
          req_d = 1'b0;
          if (we_q) state_d = S_DONE;
          else if (i_rvalid) begin
            rdata_d = fmt_rdata;
            state_d = S_DONE;
          end else state_d = S_WAIT;
        end else if (tmo_hit) begin
          req_d   = 1'b0;
          rdata_d = 32'd0;
          berr_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_WAIT: begin
        o_stall = 1'b1;
        cnt_d   = cnt_q + 8'd1;
        if (i_rvalid) begin
          rdata_d = fmt_rdata;
          state_d = S_DONE;
        end else if (tmo_hit) begin
          rdata_d = 32'd0;
          berr_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      default: begin
        berr_d  = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        mis_d   = 1'b0;
`endif
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      f3_q    <= '0;
      boff_q  <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      berr_q  <= 1'b0;
      maddr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      f3_q    <= f3_d;
      boff_q  <= boff_d;
      req_q   <= req_d;
      we_q    <= we_d;
      berr_q  <= berr_d;
      maddr_q <= maddr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) mis_q <= 1'b0;
    else          mis_q <= mis_d;
  end
`endif

  assign o_req     = req_q;
  assign o_we      = we_q;
  assign o_maddr   = maddr_q;
  assign o_wstrb   = wstrb_q;
  assign o_wdata   = wdata_q;
  assign o_rdata   = rdata_q;
  assign o_bus_err = berr_q;

endmodule
